// File: rtl/fft_pkg.sv
// Shared state encoding and constants for the butterfly front-panel sequencer.
package fft_pkg;

    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] LED_ERR = '1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_TW   = 4'd1,
        LOAD_REB  = 4'd2,
        LOAD_IMB  = 4'd3,
        LOAD_REA  = 4'd4,
        LOAD_IMA  = 4'd5,
        START     = 4'd6,
        WAIT_DONE = 4'd7,
        SHOW_REY  = 4'd8,
        SHOW_IMY  = 4'd9,
        SHOW_REZ  = 4'd10,
        SHOW_IMZ  = 4'd11
    } state_t;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus stability counter for one raw switch.
module switch_debounce #(
    parameter int DEBOUNCE_LIMIT = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);

    logic          meta_q, sync_q;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_LIMIT - 1)) begin
                stable_d = sync_q;
                rise_d   = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/fft_step_sequencer.sv
// Switch-driven operand loader, butterfly launcher and result stepper.
module fft_step_sequencer #(
    parameter int DEBOUNCE_LIMIT = 500000,
    parameter int DATA_W         = fft_pkg::DATA_W,
    parameter int TIMEOUT        = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              step_sw,
    input  logic              abort_sw,
    input  logic [DATA_W-1:0] data_sw,
    output logic [2:0]        tw_idx,
    output logic [DATA_W-1:0] rea,
    output logic [DATA_W-1:0] ima,
    output logic [DATA_W-1:0] reb,
    output logic [DATA_W-1:0] imb,
    output logic              bf_start,
    input  logic              bf_done,
    input  logic [DATA_W-1:0] rey,
    input  logic [DATA_W-1:0] imy,
    input  logic [DATA_W-1:0] rez,
    input  logic [DATA_W-1:0] imz,
    output logic [DATA_W-1:0] led,
    output logic [3:0]        state_code,
    output logic              err
);
    import fft_pkg::*;

    localparam int TCW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [2:0]        tw_q, tw_d;
    logic [DATA_W-1:0] rea_q, rea_d, ima_q, ima_d;
    logic [DATA_W-1:0] reb_q, reb_d, imb_q, imb_d;
    logic [DATA_W-1:0] rey_q, rey_d, imy_q, imy_d;
    logic [DATA_W-1:0] rez_q, rez_d, imz_q, imz_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic [DATA_W-1:0] dmeta_q, dsync_q;
    logic [TCW-1:0]    tcnt_q, tcnt_d;
    logic              err_q, err_d;
    logic              step_p, step_lvl;
    logic              abort_lvl, abort_rise;
    logic              unused_dbg;

    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_step_db (
        .clk_i   (clock),
        .rst_i   (reset),
        .raw_i   (step_sw),
        .level_o (step_lvl),
        .rise_o  (step_p)
    );

    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_abort_db (
        .clk_i   (clock),
        .rst_i   (reset),
        .raw_i   (abort_sw),
        .level_o (abort_lvl),
        .rise_o  (abort_rise)
    );

    assign unused_dbg = &{1'b0, step_lvl, abort_rise};

    always_comb begin
        state_d = state_q;
        tw_d    = tw_q;
        rea_d   = rea_q;
        ima_d   = ima_q;
        reb_d   = reb_q;
        imb_d   = imb_q;
        rey_d   = rey_q;
        imy_d   = imy_q;
        rez_d   = rez_q;
        imz_d   = imz_q;
        err_d   = err_q;
        tcnt_d  = tcnt_q;
        if (abort_lvl) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (step_p) begin
                    err_d   = 1'b0;
                    state_d = LOAD_TW;
                end
                LOAD_TW: if (step_p) begin
                    tw_d    = dsync_q[2:0];
                    state_d = LOAD_REB;
                end
                LOAD_REB: if (step_p) begin
                    reb_d   = dsync_q;
                    state_d = LOAD_IMB;
                end
                LOAD_IMB: if (step_p) begin
                    imb_d   = dsync_q;
                    state_d = LOAD_REA;
                end
                LOAD_REA: if (step_p) begin
                    rea_d   = dsync_q;
                    state_d = LOAD_IMA;
                end
                LOAD_IMA: if (step_p) begin
                    ima_d   = dsync_q;
                    state_d = START;
                end
                START: begin
                    tcnt_d  = '0;
                    state_d = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bf_done) begin
                        rey_d   = rey;
                        imy_d   = imy;
                        rez_d   = rez;
                        imz_d   = imz;
                        state_d = SHOW_REY;
                    end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                SHOW_REY: if (step_p) state_d = SHOW_IMY;
                SHOW_IMY: if (step_p) state_d = SHOW_REZ;
                SHOW_REZ: if (step_p) state_d = SHOW_IMZ;
                SHOW_IMZ: if (step_p) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Display follows the current state, so it lags a state change by one cycle
    always_comb begin
        led_d = '0;
        unique case (state_q)
            LOAD_TW, LOAD_REB, LOAD_IMB,
            LOAD_REA, LOAD_IMA: led_d = dsync_q;
            SHOW_REY: led_d = rey_q;
            SHOW_IMY: led_d = imy_q;
            SHOW_REZ: led_d = rez_q;
            SHOW_IMZ: led_d = imz_q;
            IDLE:     led_d = err_q ? DATA_W'(LED_ERR) : '0;
            default:  led_d = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tw_q    <= '0;
            rea_q   <= '0;
            ima_q   <= '0;
            reb_q   <= '0;
            imb_q   <= '0;
            rey_q   <= '0;
            imy_q   <= '0;
            rez_q   <= '0;
            imz_q   <= '0;
            led_q   <= '0;
            dmeta_q <= '0;
            dsync_q <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tw_q    <= tw_d;
            rea_q   <= rea_d;
            ima_q   <= ima_d;
            reb_q   <= reb_d;
            imb_q   <= imb_d;
            rey_q   <= rey_d;
            imy_q   <= imy_d;
            rez_q   <= rez_d;
            imz_q   <= imz_d;
            led_q   <= led_d;
            dmeta_q <= data_sw;
            dsync_q <= dmeta_q;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
        end
    end

    assign tw_idx     = tw_q;
    assign rea        = rea_q;
    assign ima        = ima_q;
    assign reb        = reb_q;
    assign imb        = imb_q;
    assign bf_start   = (state_q == START);
    assign led        = led_q;
    assign state_code = state_q;
    assign err        = err_q;

endmodule
